// File: rtl/alu_sequencer.sv
// Single-issue instruction sequencer: decodes one instruction, drives an external
// ALU for a fixed settle window, then holds the result until the consumer takes it.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  input  logic [31:0] inst,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        inst_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_dst,
  output logic        res_wr,
  output logic        branch_taken,
  output logic        trap,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_f, rd_f;
  logic [15:0] imm;
  logic        unused_bits;

  logic        dec_legal, dec_wr, dec_beq, dec_addi;
  logic [31:0] dec_a, dec_b;
  logic [1:0]  dec_op;
  logic [4:0]  dec_dst;

  logic        legal_p0, wr_p0, beq_p0, addi_p0;
  logic [4:0]  dst_p0;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  assign opcode      = inst[31:26];
  assign rt_f        = inst[20:16];
  assign rd_f        = inst[15:11];
  assign funct       = inst[5:0];
  assign imm         = inst[15:0];
  // rs index and shamt are not needed: operands arrive already read
  assign unused_bits = ^{inst[25:21], inst[10:6]};

  always_comb begin
    dec_legal = 1'b0;
    dec_wr    = 1'b0;
    dec_beq   = 1'b0;
    dec_addi  = 1'b0;
    dec_a     = '0;
    dec_b     = '0;
    dec_op    = 2'b00;
    dec_dst   = '0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21: begin dec_legal = 1'b1; dec_op = 2'b00; end
          6'h23: begin dec_legal = 1'b1; dec_op = 2'b01; end
          6'h2A: begin dec_legal = 1'b1; dec_op = 2'b11; end
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          dec_a   = rs_val;
          dec_b   = rt_val;
          dec_dst = rd_f;
          dec_wr  = 1'b1;
        end else begin
          dec_op  = 2'b00;
        end
      end
      6'h08, 6'h09: begin
        dec_legal = 1'b1;
        dec_addi  = (opcode == 6'h08);
        dec_a     = rs_val;
        dec_b     = sext16(imm);
        dec_dst   = rt_f;
        dec_wr    = 1'b1;
      end
      6'h0D: begin
        dec_legal = 1'b1;
        dec_a     = rs_val;
        dec_b     = zext16(imm);
        dec_op    = 2'b10;
        dec_dst   = rt_f;
        dec_wr    = 1'b1;
      end
      6'h0F: begin
        dec_legal = 1'b1;
        dec_b     = {imm, 16'h0000};
        dec_dst   = rt_f;
        dec_wr    = 1'b1;
      end
      6'h04: begin
        dec_legal = 1'b1;
        dec_beq   = 1'b1;
        dec_a     = rs_val;
        dec_b     = rt_val;
        dec_op    = 2'b01;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (inst_valid && inst_ready) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = legal_p0 ? SETTLE : RESP;
      SETTLE:  state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_ready   <= 1'b0;
      res_valid    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= 2'b00;
      legal_p0     <= 1'b0;
      wr_p0        <= 1'b0;
      beq_p0       <= 1'b0;
      addi_p0      <= 1'b0;
      dst_p0       <= '0;
      res_data     <= '0;
      res_dst      <= '0;
      res_wr       <= 1'b0;
      branch_taken <= 1'b0;
      trap         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      inst_ready <= (state_nxt == IDLE);
      res_valid  <= (state_nxt == RESP);
      // p0: decoded instruction captured on the accept edge
      if (accept) begin
        alu_a    <= dec_a;
        alu_b    <= dec_b;
        alu_op   <= dec_op;
        legal_p0 <= dec_legal;
        wr_p0    <= dec_wr;
        beq_p0   <= dec_beq;
        addi_p0  <= dec_addi;
        dst_p0   <= dec_dst;
      end
      // result: ALU sampled at end of SETTLE, or illegal reported straight from ISSUE
      if (state == SETTLE) begin
        res_data     <= beq_p0 ? 32'h0 : alu_out;
        res_dst      <= dst_p0;
        res_wr       <= wr_p0 && !(addi_p0 && alu_ovf);
        branch_taken <= beq_p0 && alu_zero;
        trap         <= addi_p0 && alu_ovf;
        illegal      <= 1'b0;
      end else if (state == ISSUE && !legal_p0) begin
        res_data     <= '0;
        res_dst      <= '0;
        res_wr       <= 1'b0;
        branch_taken <= 1'b0;
        trap         <= 1'b0;
        illegal      <= 1'b1;
      end else if (state == RESP && res_ready) begin
        res_data     <= '0;
        res_dst      <= '0;
        res_wr       <= 1'b0;
        branch_taken <= 1'b0;
        trap         <= 1'b0;
        illegal      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions, a behavioural ALU,
// and a negedge monitor that checks each delivered result against a queue.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        inst_ready;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zero, alu_ovf;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [4:0]  res_dst;
  logic        res_wr, branch_taken, trap, illegal;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        wr;
    logic        br;
    logic        trap;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cnt = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .rs_val(rs_val), .rt_val(rt_val), .inst_ready(inst_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_dst(res_dst), .res_wr(res_wr), .branch_taken(branch_taken),
    .trap(trap), .illegal(illegal)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU with signed overflow on add/sub
  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_out = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      2'b01: begin
        alu_out = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = {31'b0, ($signed(alu_a) < $signed(alu_b))};
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst && inst_valid && inst_ready) acc_cnt++;

  initial begin : monitor
    exp_t        e;
    bit          seen;
    logic [31:0] sd;
    logic [4:0]  sdst;
    logic [3:0]  sfl;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen = 0;
      end else if (res_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_res_valid", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_dst", {27'b0, res_dst}, {27'b0, e.dst});
            chk("res_wr", {31'b0, res_wr}, {31'b0, e.wr});
            chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.br});
            chk("trap", {31'b0, trap}, {31'b0, e.trap});
            chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
            chk("latency", cyc - e.acc, e.lat);
            sd   = res_data;
            sdst = res_dst;
            sfl  = {res_wr, branch_taken, trap, illegal};
            seen = 1;
          end
        end else begin
          chk("hold_data", res_data, sd);
          chk("hold_dst", {27'b0, res_dst}, {27'b0, sdst});
          chk("hold_flags", {28'b0, res_wr, branch_taken, trap, illegal}, {28'b0, sfl});
        end
        if (res_ready) seen = 0;
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (inst_ready) break;
      @(posedge clk); #1;
    end
    chk("inst_ready_timeout", {31'b0, inst_ready}, 32'd1);
  endtask

  task automatic run(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [1:0] eop,
                     input logic [31:0] ed, input logic [4:0] edst,
                     input logic ewr, input logic ebr, input logic etrap, input logic eill,
                     input int stall);
    exp_t e;
    int   a0;
    wait_ready();
    res_ready  = (stall == 0);
    inst       = i;
    rs_val     = rs;
    rt_val     = rt;
    inst_valid = 1'b1;
    a0         = acc_cnt;
    @(posedge clk); #1;
    e.data = ed; e.dst = edst; e.wr = ewr; e.br = ebr; e.trap = etrap; e.ill = eill;
    e.lat  = eill ? 1 : 2;
    e.acc  = cyc;
    q.push_back(e);
    if (stall == 0) inst_valid = 1'b0;
    if (!eill) begin
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_op", {30'b0, alu_op}, {30'b0, eop});
      @(posedge clk); #1;
      chk("alu_a_settle", alu_a, ea);
      chk("alu_b_settle", alu_b, eb);
    end
    if (stall > 0) begin
      for (int k = 0; k < 10 && !res_valid; k++) begin
        @(posedge clk); #1;
      end
      chk("stall_res_valid", {31'b0, res_valid}, 32'd1);
      repeat (stall) begin
        @(posedge clk); #1;
        chk("stall_inst_ready", {31'b0, inst_ready}, 32'd0);
        chk("stall_res_valid_hold", {31'b0, res_valid}, 32'd1);
      end
      res_ready  = 1'b1;
      inst_valid = 1'b0;
    end
    wait_ready();
    chk("accept_count", acc_cnt - a0, 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    // reset state
    #1;
    chk("rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {30'b0, alu_op}, 32'd0);
    chk("rst_flags", {27'b0, res_wr, branch_taken, trap, illegal, res_dst != 5'd0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rel_inst_ready_before_edge", {31'b0, inst_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_inst_ready_after_edge", {31'b0, inst_ready}, 32'd1);

    // addu r3 = 5 + 7
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'd5, 32'd7,
        32'd5, 32'd7, 2'b00, 32'd12, 5'd3, 1, 0, 0, 0, 0);
    // addi overflow traps
    run({6'h08, 5'd1, 5'd4, 16'h0001}, 32'h7FFFFFFF, 32'd0,
        32'h7FFFFFFF, 32'd1, 2'b00, 32'h80000000, 5'd4, 0, 0, 1, 0, 0);
    // addiu same operands: no trap
    run({6'h09, 5'd1, 5'd4, 16'h0001}, 32'h7FFFFFFF, 32'd0,
        32'h7FFFFFFF, 32'd1, 2'b00, 32'h80000000, 5'd4, 1, 0, 0, 0, 0);
    // addi with negative immediate: 5 + (-1)
    run({6'h08, 5'd1, 5'd6, 16'hFFFF}, 32'd5, 32'd0,
        32'd5, 32'hFFFFFFFF, 2'b00, 32'd4, 5'd6, 1, 0, 0, 0, 0);
    // beq taken / not taken
    run({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1234,
        32'h1234, 32'h1234, 2'b01, 32'd0, 5'd0, 0, 1, 0, 0, 0);
    run({6'h04, 5'd1, 5'd2, 16'h0010}, 32'h1234, 32'h1235,
        32'h1234, 32'h1235, 2'b01, 32'd0, 5'd0, 0, 0, 0, 0, 0);
    // slt -1 < 1
    run({6'h00, 5'd1, 5'd2, 5'd7, 5'd0, 6'h2A}, 32'hFFFFFFFF, 32'd1,
        32'hFFFFFFFF, 32'd1, 2'b11, 32'd1, 5'd7, 1, 0, 0, 0, 0);
    // lui 0xABCD
    run({6'h0F, 5'd0, 5'd9, 16'hABCD}, 32'h55555555, 32'd0,
        32'd0, 32'hABCD0000, 2'b00, 32'hABCD0000, 5'd9, 1, 0, 0, 0, 0);
    // ori zero-extends
    run({6'h0D, 5'd1, 5'd5, 16'h8001}, 32'h12340000, 32'd0,
        32'h12340000, 32'h00008001, 2'b10, 32'h12348001, 5'd5, 1, 0, 0, 0, 0);
    // subu with consumer stalled 3 cycles, inst_valid held
    run({6'h00, 5'd1, 5'd2, 5'd2, 5'd0, 6'h23}, 32'd10, 32'd3,
        32'd10, 32'd3, 2'b01, 32'd7, 5'd2, 1, 0, 0, 0, 3);
    // illegal opcode 0x3F and unsupported funct (add, 0x20)
    run({6'h3F, 26'h0}, 32'd1, 32'd2,
        32'd0, 32'd0, 2'b00, 32'd0, 5'd0, 0, 0, 0, 1, 0);
    run({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd1, 32'd2,
        32'd0, 32'd0, 2'b00, 32'd0, 5'd0, 0, 0, 0, 1, 0);

    // reset during SETTLE abandons the instruction
    wait_ready();
    res_ready  = 1'b1;
    inst       = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    rs_val     = 32'd100;
    rt_val     = 32'd23;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_rst_inst_ready", {31'b0, inst_ready}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_res_data", res_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mid_rel_inst_ready_before", {31'b0, inst_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rel_inst_ready_after", {31'b0, inst_ready}, 32'd1);
    chk("mid_rel_res_valid", {31'b0, res_valid}, 32'd0);
    run({6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h21}, 32'd100, 32'd23,
        32'd100, 32'd23, 2'b00, 32'd123, 5'd8, 1, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
